// File: rtl/sram_dp_be.sv
// Dual-port byte-writable RAM: port A read/write with byte enables, port B read-only.
// Optional zero-fill sequencer after reset; read latency selectable between 0 and 1.
module sram_dp_be #(
    parameter int addr_width     = 16,
    parameter int data_width     = 32,
    parameter int read_latency   = 0,
    parameter int clear_on_reset = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      init_busy,
    input  logic                      a_en,
    input  logic                      a_we,
    input  logic [data_width/8-1:0]   a_be,
    input  logic [addr_width-1:0]     a_addr,
    input  logic [data_width-1:0]     a_wr_data,
    output logic [data_width-1:0]     a_rd_data,
    output logic                      a_rd_valid,
    input  logic                      b_en,
    input  logic [addr_width-1:0]     b_addr,
    output logic [data_width-1:0]     b_rd_data,
    output logic                      b_rd_valid
);

    localparam int depth     = 1 << addr_width;
    localparam int num_bytes = data_width / 8;

    localparam logic [0:0] st_clear = 1'b0;
    localparam logic [0:0] st_ready = 1'b1;

    logic [0:0]            state;
    logic [addr_width-1:0] clr_cnt;
    logic [data_width-1:0] mem [depth];
    logic                  wr_en;
    logic                  a_rd_ok;
    logic                  b_rd_ok;

    // Clear walks every address once; READY is held until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= (clear_on_reset != 0) ? st_clear : st_ready;
            clr_cnt <= '0;
        end else if (state == st_clear) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (&clr_cnt) begin
                state <= st_ready;
            end
        end
    end

    assign init_busy = (state == st_clear);
    assign wr_en     = a_en & a_we & ~init_busy;
    assign a_rd_ok   = a_en & ~init_busy;
    assign b_rd_ok   = b_en & ~init_busy;

    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < num_bytes; i++) begin
                if (a_be[i]) begin
                    mem[a_addr][8*i +: 8] <= a_wr_data[8*i +: 8];
                end
            end
        end
    end

    generate
        if (read_latency == 0) begin : g_lat0
            // Array updates at the edge, so a same-cycle write is not visible yet.
            assign a_rd_valid = a_rd_ok;
            assign b_rd_valid = b_rd_ok;
            assign a_rd_data  = a_rd_ok ? mem[a_addr] : '0;
            assign b_rd_data  = b_rd_ok ? mem[b_addr] : '0;
        end else begin : g_lat1
            logic [data_width-1:0] a_fwd;
            logic [data_width-1:0] b_fwd;

            // Write-first: bytes written this cycle replace the stored bytes.
            always_comb begin
                a_fwd = mem[a_addr];
                b_fwd = mem[b_addr];
                for (int i = 0; i < num_bytes; i++) begin
                    if (wr_en && a_be[i]) begin
                        a_fwd[8*i +: 8] = a_wr_data[8*i +: 8];
                        if (b_addr == a_addr) begin
                            b_fwd[8*i +: 8] = a_wr_data[8*i +: 8];
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rd_valid <= 1'b0;
                    b_rd_valid <= 1'b0;
                    a_rd_data  <= '0;
                    b_rd_data  <= '0;
                end else begin
                    a_rd_valid <= a_rd_ok;
                    b_rd_valid <= b_rd_ok;
                    a_rd_data  <= a_rd_ok ? a_fwd : '0;
                    b_rd_data  <= b_rd_ok ? b_fwd : '0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sram_dp_be.sv
// Bench for sram_dp_be: one latency-0 and one latency-1 instance share all inputs;
// expected read words are queued at issue time and popped whenever a port shows valid.
module tb_sram_dp_be;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_en, a_we, b_en;
    logic [3:0]  a_be, a_addr, b_addr;
    logic [31:0] a_wr_data;

    logic        busy0, va0, vb0, busy1, va1, vb1;
    logic [31:0] ra0, rb0, ra1, rb1;

    logic [31:0] q_a0[$], q_b0[$], q_a1[$], q_b1[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_dp_be #(.addr_width(4), .data_width(32), .read_latency(0), .clear_on_reset(1)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .init_busy(busy0),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wr_data(a_wr_data),
        .a_rd_data(ra0), .a_rd_valid(va0),
        .b_en(b_en), .b_addr(b_addr), .b_rd_data(rb0), .b_rd_valid(vb0)
    );

    sram_dp_be #(.addr_width(4), .data_width(32), .read_latency(1), .clear_on_reset(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .init_busy(busy1),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wr_data(a_wr_data),
        .a_rd_data(ra1), .a_rd_valid(va1),
        .b_en(b_en), .b_addr(b_addr), .b_rd_data(rb1), .b_rd_valid(vb1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitors: a valid word must match the oldest queued expectation; idle data must be 0.
    always @(negedge clk) begin
        if (va0) begin
            if (q_a0.size() == 0) check("a0 valid with nothing pending", 32'(va0), 32'h0);
            else check("a0 data", ra0, q_a0.pop_front());
        end else check("a0 idle data", ra0, 32'h0);
    end

    always @(negedge clk) begin
        if (vb0) begin
            if (q_b0.size() == 0) check("b0 valid with nothing pending", 32'(vb0), 32'h0);
            else check("b0 data", rb0, q_b0.pop_front());
        end else check("b0 idle data", rb0, 32'h0);
    end

    always @(negedge clk) begin
        if (va1) begin
            if (q_a1.size() == 0) check("a1 valid with nothing pending", 32'(va1), 32'h0);
            else check("a1 data", ra1, q_a1.pop_front());
        end else check("a1 idle data", ra1, 32'h0);
    end

    always @(negedge clk) begin
        if (vb1) begin
            if (q_b1.size() == 0) check("b1 valid with nothing pending", 32'(vb1), 32'h0);
            else check("b1 data", rb1, q_b1.pop_front());
        end else check("b1 idle data", rb1, 32'h0);
    end

    // One bus cycle; ea*/eb* are the hand-computed words for the lat0 / lat1 instances.
    task automatic cyc(input logic ae, input logic we, input logic [3:0] be, input logic [3:0] aa,
                       input logic [31:0] wd, input logic ben, input logic [3:0] ba,
                       input logic [31:0] ea0, input logic [31:0] ea1,
                       input logic [31:0] eb0, input logic [31:0] eb1);
        @(posedge clk); #1;
        a_en = ae; a_we = we; a_be = be; a_addr = aa; a_wr_data = wd;
        b_en = ben; b_addr = ba;
        if (ae) begin q_a0.push_back(ea0); q_a1.push_back(ea1); end
        if (ben) begin q_b0.push_back(eb0); q_b1.push_back(eb1); end
    endtask

    task automatic wr(input logic [3:0] aa, input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] old_w, input logic [31:0] new_w);
        cyc(1'b1, 1'b1, be, aa, wd, 1'b0, 4'h0, old_w, new_w, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [3:0] aa, input logic [3:0] ba,
                      input logic [31:0] ea, input logic [31:0] eb);
        cyc(1'b1, 1'b0, 4'h0, aa, 32'h0, 1'b1, ba, ea, ea, eb, eb);
    endtask

    task automatic idle(input logic [3:0] aa);
        cyc(1'b0, 1'b0, 4'h0, aa, 32'h0, 1'b0, aa, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    // Called at posedge+1 right after rst_n rises; counts cycles with init_busy high.
    task automatic count_busy(output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy0 && !busy1) break;
            n0 += int'(busy0);
            n1 += int'(busy1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int n0, n1;
        rst_n = 1'b0;
        a_en = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 4'h0; a_wr_data = 32'h0;
        b_en = 1'b0; b_addr = 4'h0;
        @(posedge clk); #1;
        check("reset busy lat0", 32'(busy0), 32'h1);
        check("reset busy lat1", 32'(busy1), 32'h1);
        check("reset a_rd_valid lat1", 32'(va1), 32'h0);
        check("reset b_rd_data lat1", rb1, 32'h0);
        @(posedge clk); #1;

        // Clear after reset, with a write and reads attempted throughout the busy window.
        rst_n = 1'b1;
        a_en = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 4'h0; a_wr_data = 32'hDEADBEEF;
        b_en = 1'b1; b_addr = 4'h0;
        count_busy(n0, n1);
        a_en = 1'b0; a_we = 1'b0; b_en = 1'b0;
        check("clear length lat0", 32'(n0), 32'd16);
        check("clear length lat1", 32'(n1), 32'd16);
        for (int i = 0; i < 16; i++) rd(4'(i), 4'(15 - i), 32'h0, 32'h0);

        // Byte-enable writes.
        wr(4'd3, 32'hAABBCCDD, 4'hF, 32'h0, 32'hAABBCCDD);
        wr(4'd3, 32'h11223344, 4'b0101, 32'hAABBCCDD, 32'hAA22CC44);
        rd(4'd3, 4'd3, 32'hAA22CC44, 32'hAA22CC44);

        // Same-address write/read collision, full word then single byte.
        wr(4'd5, 32'h1, 4'hF, 32'h0, 32'h1);
        cyc(1'b1, 1'b1, 4'hF, 4'd5, 32'h2, 1'b1, 4'd5, 32'h1, 32'h2, 32'h1, 32'h2);
        rd(4'd5, 4'd5, 32'h2, 32'h2);
        wr(4'd5, 32'h1, 4'hF, 32'h2, 32'h1);
        cyc(1'b1, 1'b1, 4'b1000, 4'd5, 32'hFF00_0000, 1'b1, 4'd5,
            32'h1, 32'hFF00_0001, 32'h1, 32'hFF00_0001);
        rd(4'd5, 4'd5, 32'hFF00_0001, 32'hFF00_0001);

        // Write on A while B reads a different word; then an all-disabled byte write.
        cyc(1'b1, 1'b1, 4'hF, 4'd6, 32'h12345678, 1'b1, 4'd3,
            32'h0, 32'h12345678, 32'hAA22CC44, 32'hAA22CC44);
        wr(4'd6, 32'hFFFFFFFF, 4'h0, 32'h12345678, 32'h12345678);
        wr(4'd15, 32'hCAFEF00D, 4'hF, 32'h0, 32'hCAFEF00D);
        rd(4'd6, 4'd15, 32'h12345678, 32'hCAFEF00D);

        // Disabled reads at a populated address must present zeros.
        rd(4'd3, 4'd3, 32'hAA22CC44, 32'hAA22CC44);
        idle(4'd3);
        cyc(1'b0, 1'b0, 4'h0, 4'd3, 32'h0, 1'b1, 4'd15, 32'h0, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D);
        idle(4'd3);
        idle(4'd3);

        // Reset during the clear sequence restarts it from address 0.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            check("busy before mid-clear reset lat0", 32'(busy0), 32'h1);
            check("busy before mid-clear reset lat1", 32'(busy1), 32'h1);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("busy during reset lat0", 32'(busy0), 32'h1);
            check("busy during reset lat1", 32'(busy1), 32'h1);
        end
        rst_n = 1'b1;
        count_busy(n0, n1);
        check("restarted clear length lat0", 32'(n0), 32'd16);
        check("restarted clear length lat1", 32'(n1), 32'd16);
        for (int i = 0; i < 16; i++) rd(4'(i), 4'(15 - i), 32'h0, 32'h0);

        idle(4'd0);
        idle(4'd0);
        idle(4'd0);
        @(negedge clk); #1;
        check("a0 reads left unanswered", 32'(q_a0.size()), 32'h0);
        check("b0 reads left unanswered", 32'(q_b0.size()), 32'h0);
        check("a1 reads left unanswered", 32'(q_a1.size()), 32'h0);
        check("b1 reads left unanswered", 32'(q_b1.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
